tile_fetcher: RTL and testbench

Scanline tile fetcher for the tile video path. On each line-start pulse it walks the tile map row for the current scanline and reads the tile index and attribute bytes. It then fetches the four 4bpp pattern bytes for the tile's pixel row and streams 8 pixels per tile (colour index plus palette id) to the palette/pixel-output stage over a valid/ready handshake. It sits directly downstream of the 64 KB system RAM and drives that RAM's address, using its combinational read data.

---
 rtl/tile_pkg.sv | 23 ++
 rtl/pixel_shifter.sv | 64 ++++++
 rtl/tile_fetcher.sv | 160 ++++++++++++++++
 tb/tb_tile_fetcher.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared FSM state, tile geometry and attribute layout for the scanline tile fetcher.
package tile_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_IDX, ST_ATTR, ST_PAT0, ST_PAT1, ST_PAT2, ST_PAT3
  } state_t;

  localparam int TileBytes  = 32;
  localparam int RowBytes   = 4;
  localparam int TilePixels = 8;

  localparam int AttrFlipH  = 7;
  localparam int AttrFlipV  = 6;
  localparam int AttrPalHi  = 1;
  localparam int AttrPalLo  = 0;

  // Reverses the order of the eight 4-bit pixels in a pattern row.
  function automatic logic [31:0] reverse_nibbles(input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = d[4*(7-i) +: 4];
    return r;
  endfunction
endpackage

// File: rtl/pixel_shifter.sv
// One-entry tile buffer feeding an 8-pixel shifter; 1 cycle from buffer to shifter, output held under backpressure.
// The buffer refills the shifter when empty or as its last pixel is accepted, so tiles stream gaplessly.
module pixel_shifter
  import tile_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        buf_wr,
  input  logic [31:0] buf_dat,
  input  logic        buf_fliph,
  input  logic [1:0]  buf_pal,
  output logic        buf_full,
  output logic        buf_take,
  output logic        pix_vld,
  input  logic        pix_rdy,
  output logic [3:0]  pix_col,
  output logic [1:0]  pix_pal
);
  logic [31:0] tb_dat;
  logic        tb_fliph;
  logic [1:0]  tb_pal;
  logic [31:0] sh_dat;
  logic [3:0]  sh_cnt;
  logic        xfer;
  logic        last;

  assign xfer     = pix_vld & pix_rdy;
  assign last     = xfer && (sh_cnt == 4'd1);
  assign buf_take = buf_full && (!pix_vld || last);
  assign pix_col  = sh_dat[31:28];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full <= 1'b0;
      tb_dat   <= '0;
      tb_fliph <= 1'b0;
      tb_pal   <= '0;
      sh_dat   <= '0;
      sh_cnt   <= '0;
      pix_vld  <= 1'b0;
      pix_pal  <= '0;
    end else begin
      if (buf_wr) begin
        buf_full <= 1'b1;
        tb_dat   <= buf_dat;
        tb_fliph <= buf_fliph;
        tb_pal   <= buf_pal;
      end else if (buf_take) begin
        buf_full <= 1'b0;
      end

      if (buf_take) begin
        sh_dat  <= tb_fliph ? reverse_nibbles(tb_dat) : tb_dat;
        sh_cnt  <= 4'(TilePixels);
        pix_vld <= 1'b1;
        pix_pal <= tb_pal;
      end else if (xfer) begin
        sh_dat <= {sh_dat[27:0], 4'h0};
        sh_cnt <= sh_cnt - 4'd1;
        if (last) pix_vld <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/tile_fetcher.sv
// Scanline tile fetcher: per line, reads map entries and pattern rows from RAM and streams 8 pixels per tile.
// Flip support is built when TILE_FETCHER_FLIP_EN is defined; otherwise attribute bits 7/6 are ignored.
module tile_fetcher
  import tile_pkg::*;
#(
  parameter int AddrBits     = 16,
  parameter int MapBase      = 0,
  parameter int PatternBase  = 8192,
  parameter int MapWidth     = 64,
  parameter int VisibleTiles = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lineStart,
  input  logic [7:0]          lineY,
  output logic [AddrBits-1:0] ramAddress,
  input  logic [7:0]          ramData,
  output logic                pixelValid,
  input  logic                pixelReady,
  output logic [3:0]          pixelColor,
  output logic [1:0]          pixelPalette,
  output logic                lineDone,
  output logic                busy
);
  localparam int TW         = (VisibleTiles > 1) ? $clog2(VisibleTiles) : 1;
  localparam int LinePixels = VisibleTiles * TilePixels;
  localparam int PW         = (LinePixels > 1) ? $clog2(LinePixels) : 1;

  state_t        state;
  logic [7:0]    line_y;
  logic [7:0]    idx;
  logic [7:0]    b0, b1, b2;
  logic [TW-1:0] t;
  logic [PW-1:0] pix_cnt;
  logic          fliph;
  logic [1:0]    pal;
  logic          attr_fliph;
  logic          attr_flipv;
  logic [2:0]    row;
  logic          buf_full;
  logic          buf_take;
  logic          tile_wr;

  function automatic logic [AddrBits-1:0] map_addr(input logic [7:0] y, input logic [TW-1:0] tile);
    return AddrBits'(MapBase) + AddrBits'(y[7:3]) * AddrBits'(MapWidth * 2) + (AddrBits'(tile) << 1);
  endfunction

  function automatic logic [AddrBits-1:0] pat_addr(input logic [7:0] index, input logic [2:0] r);
    return AddrBits'(PatternBase) + AddrBits'(index) * AddrBits'(TileBytes) + AddrBits'(r) * AddrBits'(RowBytes);
  endfunction

`ifdef TILE_FETCHER_FLIP_EN
  assign attr_fliph = ramData[AttrFlipH];
  assign attr_flipv = ramData[AttrFlipV];
`else
  assign attr_fliph = 1'b0;
  assign attr_flipv = 1'b0;
`endif

  // Row select uses the attribute byte on the bus during ATTR; 7-y is ~y in 3 bits.
  assign row     = attr_flipv ? ~line_y[2:0] : line_y[2:0];
  assign tile_wr = (state == ST_PAT3) && (!buf_full || buf_take);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ramAddress <= '0;
      line_y     <= '0;
      idx        <= '0;
      b0         <= '0;
      b1         <= '0;
      b2         <= '0;
      t          <= '0;
      pix_cnt    <= '0;
      fliph      <= 1'b0;
      pal        <= '0;
      lineDone   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      lineDone <= 1'b0;
      if (pixelValid && pixelReady) begin
        if (pix_cnt == PW'(LinePixels - 1)) begin
          lineDone <= 1'b1;
          busy     <= 1'b0;
          pix_cnt  <= '0;
        end else begin
          pix_cnt <= pix_cnt + PW'(1);
        end
      end

      case (state)
        ST_IDLE: begin
          // Busy while idle means the last tile is still draining; a new line waits.
          if (lineStart && !busy) begin
            line_y     <= lineY;
            t          <= '0;
            pix_cnt    <= '0;
            busy       <= 1'b1;
            ramAddress <= map_addr(lineY, '0);
            state      <= ST_IDX;
          end
        end
        ST_IDX: begin
          idx        <= ramData;
          ramAddress <= ramAddress + AddrBits'(1);
          state      <= ST_ATTR;
        end
        ST_ATTR: begin
          fliph      <= attr_fliph;
          pal        <= ramData[AttrPalHi:AttrPalLo];
          ramAddress <= pat_addr(idx, row);
          state      <= ST_PAT0;
        end
        ST_PAT0: begin
          b0         <= ramData;
          ramAddress <= ramAddress + AddrBits'(1);
          state      <= ST_PAT1;
        end
        ST_PAT1: begin
          b1         <= ramData;
          ramAddress <= ramAddress + AddrBits'(1);
          state      <= ST_PAT2;
        end
        ST_PAT2: begin
          b2         <= ramData;
          ramAddress <= ramAddress + AddrBits'(1);
          state      <= ST_PAT3;
        end
        ST_PAT3: begin
          if (tile_wr) begin
            if (t == TW'(VisibleTiles - 1)) begin
              ramAddress <= '0;
              state      <= ST_IDLE;
            end else begin
              t          <= t + TW'(1);
              ramAddress <= map_addr(line_y, t + TW'(1));
              state      <= ST_IDX;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pixel_shifter u_shifter (
    .clk       (clk),
    .rst_n     (reset),
    .buf_wr    (tile_wr),
    .buf_dat   ({b0, b1, b2, ramData}),
    .buf_fliph (fliph),
    .buf_pal   (pal),
    .buf_full  (buf_full),
    .buf_take  (buf_take),
    .pix_vld   (pixelValid),
    .pix_rdy   (pixelReady),
    .pix_col   (pixelColor),
    .pix_pal   (pixelPalette)
  );
endmodule

// File: tb/tb_tile_fetcher.sv
// Bench for tile_fetcher: RAM array, line-level pixel/address model, per-cycle compare process.
module tb_tile_fetcher;
  logic        clk = 1'b0;
  logic        reset;
  logic        lineStart;
  logic [7:0]  lineY;
  logic [15:0] ramAddress;
  logic [7:0]  ramData;
  logic        pixelValid;
  logic        pixelReady;
  logic [3:0]  pixelColor;
  logic [1:0]  pixelPalette;
  logic        lineDone;
  logic        busy;

  logic [7:0] mem [0:65535];
  assign ramData = mem[ramAddress];

  always #5 clk = ~clk;

  tile_fetcher dut (
    .clk          (clk),
    .reset        (reset),
    .lineStart    (lineStart),
    .lineY        (lineY),
    .ramAddress   (ramAddress),
    .ramData      (ramData),
    .pixelValid   (pixelValid),
    .pixelReady   (pixelReady),
    .pixelColor   (pixelColor),
    .pixelPalette (pixelPalette),
    .lineDone     (lineDone),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;
  int exp_pix[$];
  int exp_addr[$];
  int cyc, first_vld, ld_cnt, ld_cyc, xfer_cnt, addr_n;
  int prev_pix, last_addr;
  bit cmp_en = 1'b0;
  bit prev_stall, have_last;
  int cap_pix [24];
  int cap_addr[24];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line model: the pixel stream and the RAM read sequence implied by map and pattern contents.
  task automatic build_expect(input int y);
    exp_pix.delete();
    exp_addr.delete();
    for (int t = 0; t < 32; t++) begin
      int ma, idx, at, row, pa, k2, bt, nib;
      bit fh, fv;
      ma  = ((y / 8) * 128 + t * 2) % 65536;
      idx = mem[ma];
      at  = mem[(ma + 1) % 65536];
      fh  = 1'b0;
      fv  = 1'b0;
`ifdef TILE_FETCHER_FLIP_EN
      fh = at[7];
      fv = at[6];
`endif
      row = fv ? 7 - (y % 8) : y % 8;
      pa  = (8192 + idx * 32 + row * 4) % 65536;
      exp_addr.push_back(ma);
      exp_addr.push_back((ma + 1) % 65536);
      for (int b = 0; b < 4; b++) exp_addr.push_back((pa + b) % 65536);
      for (int k = 0; k < 8; k++) begin
        k2  = fh ? 7 - k : k;
        bt  = mem[(pa + k2 / 2) % 65536];
        nib = (k2 % 2 == 0) ? (bt >> 4) : (bt & 15);
        exp_pix.push_back((at & 3) * 16 + nib);
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      int act, e;
      cyc++;
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (pixelValid && first_vld == 0) first_vld = cyc;
      act = pixelPalette * 16 + pixelColor;
      if (prev_stall) begin
        chk("hold_valid", pixelValid, 1);
        chk("hold_pixel", act, prev_pix);
      end
      prev_stall = pixelValid && !pixelReady;
      prev_pix   = act;
      if (pixelValid && pixelReady) begin
        e = (exp_pix.size() > 0) ? exp_pix.pop_front() : -1;
        chk("pixel", act, e);
        if (xfer_cnt < 24) cap_pix[xfer_cnt] = act;
        xfer_cnt++;
      end
      if (lineDone) begin
        ld_cnt++;
        ld_cyc = cyc;
        chk("xfers_at_linedone", xfer_cnt, 256);
        chk("busy_at_linedone", busy, 0);
      end
      // Collapse repeats: a stalled PAT3 holds its address, so each read appears once.
      if (busy && (!have_last || int'(ramAddress) != last_addr)) begin
        have_last = 1'b1;
        last_addr = ramAddress;
        if (exp_addr.size() > 0) begin
          e = exp_addr.pop_front();
          chk("ram_address", ramAddress, e);
          if (addr_n < 24) cap_addr[addr_n] = ramAddress;
          addr_n++;
        end
      end
    end
  end

  task automatic start_line(input int y);
    build_expect(y);
    cyc = 0; first_vld = 0; ld_cnt = 0; ld_cyc = 0; xfer_cnt = 0; addr_n = 0;
    prev_stall = 1'b0; have_last = 1'b0;
    for (int i = 0; i < 24; i++) begin cap_pix[i] = -1; cap_addr[i] = -1; end
    @(posedge clk); #2;
    lineStart = 1'b1;
    lineY     = 8'(y);
    @(posedge clk);
    cyc    = 0;
    cmp_en = 1'b1;
    #2 lineStart = 1'b0;
  endtask

  task automatic run_line(input int y, input bit rnd);
    pixelReady = 1'b1;
    start_line(y);
    for (int i = 0; i < 4000 && ld_cnt == 0; i++) begin
      @(posedge clk); #2;
      pixelReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    pixelReady = 1'b1;
    repeat (5) @(posedge clk);
    #2 cmp_en = 1'b0;
    chk("linedone_pulses", ld_cnt, 1);
    chk("pixels_left", exp_pix.size(), 0);
    chk("line_transfers", xfer_cnt, 256);
    chk("reads_done", addr_n, 192);
    if (!rnd) begin
      chk("first_valid_cycle", first_vld, 8);
      chk("linedone_cycle", ld_cyc, 264);
    end
  endtask

  initial begin
    int c[24];
    int seen_ld, seen_vld;
    for (int a = 0; a < 65536; a++) mem[a] = 8'((a * 37) ^ (a >> 5) ^ 8'h5c);
    mem[0] = 8'h00; mem[1] = 8'h00;
    mem[2] = 8'h00; mem[3] = 8'h81;
    mem[4] = 8'h00; mem[5] = 8'h42;
    mem[8192] = 8'h0e; mem[8193] = 8'h80; mem[8194] = 8'h88; mem[8195] = 8'h00;
    for (int a = 8220; a < 8224; a++) mem[a] = 8'h00;
    mem[2944] = 8'd66; mem[2945] = 8'h37; mem[10304] = 8'h5a;

    reset = 1'b0; lineStart = 1'b0; lineY = '0; pixelReady = 1'b1; cyc = 0;
    repeat (2) @(negedge clk);
    chk("rst_ram_address", ramAddress, 0);
    chk("rst_pixel_valid", pixelValid, 0);
    chk("rst_line_done", lineDone, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #2 reset = 1'b1;

    // Line 0, ready high: plain tile, flipH tile, flipV tile in positions 0..2.
    run_line(0, 1'b0);
    c = '{0,14,8,0,8,8,0,0, 0,0,8,8,0,8,14,0, 0,0,0,0,0,0,0,0};
`ifndef TILE_FETCHER_FLIP_EN
    c = '{0,14,8,0,8,8,0,0, 0,14,8,0,8,8,0,0, 0,14,8,0,8,8,0,0};
`endif
    for (int i = 0; i < 24; i++) chk("line0_literal_pixel", cap_pix[i], (i / 8) * 16 + c[i]);
    chk("line0_idx_addr", cap_addr[0], 0);
    chk("line0_attr_addr", cap_addr[1], 1);
    chk("line0_pat0_addr", cap_addr[2], 8192);
`ifdef TILE_FETCHER_FLIP_EN
    for (int b = 0; b < 4; b++) chk("tile2_flipv_addr", cap_addr[14 + b], 8220 + b);
`else
    for (int b = 0; b < 4; b++) chk("tile2_row0_addr", cap_addr[14 + b], 8192 + b);
`endif

    // Same line under pseudo-random backpressure.
    run_line(0, 1'b1);
    for (int i = 0; i < 24; i++) chk("stalled_literal_pixel", cap_pix[i], (i / 8) * 16 + c[i]);

    // Map row 23 with a non-zero tile index and palette 3.
    run_line(184, 1'b0);
    chk("y184_idx_addr", cap_addr[0], 2944);
    chk("y184_attr_addr", cap_addr[1], 2945);
    chk("y184_pat0_addr", cap_addr[2], 10304);
    chk("y184_first_pixel", cap_pix[0], 3 * 16 + 5);

    // Reset in the middle of a line, then a fresh line.
    pixelReady = 1'b1;
    start_line(9);
    for (int i = 0; i < 2000 && xfer_cnt < 100; i++) begin @(posedge clk); #2; end
    chk("midline_progress", xfer_cnt, 100);
    reset  = 1'b0;
    cmp_en = 1'b0;
    @(negedge clk);
    chk("midrst_ram_address", ramAddress, 0);
    chk("midrst_pixel_valid", pixelValid, 0);
    chk("midrst_line_done", lineDone, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pixel", pixelPalette * 16 + pixelColor, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    seen_ld = 0; seen_vld = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (lineDone) seen_ld++;
      if (pixelValid) seen_vld++;
    end
    chk("post_reset_linedone", seen_ld, 0);
    chk("post_reset_valid", seen_vld, 0);
    run_line(9, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
